// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin mux arbiter.
// Exports default N/W, the select-width function and reset pointer.
package mux_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    // Pointer value after reset: requester 0 has first priority.
    localparam int RST_PTR = 0;

    function automatic int sw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first req at or above ptr, wrapping.
// Ports: req[N], ptr[SW] in; gnt[N] one-hot, idx[SW], any out.
module rr_pick
    import mux_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int SW = sw_of(DEF_N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] dbl;

    // The upper copy of req lets a scan starting at ptr wrap
    // around without a modulo in the search.
    always_comb begin
        dbl = {req, req};
        gnt = '0;
        idx = ptr;
        any = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (!any && dbl[j] && (j >= int'(ptr))) begin
                any = 1'b1;
                gnt = N'(1) << (j % N);
                idx = SW'(j % N);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N:1 round-robin arbitrating mux with a registered valid/ready output.
// Ports: clk, rst_n, in_valid[N], in_data[N*W], in_ready[N], sel[SW],
//   out_valid, out_data[W], out_src[SW], out_ready.
// Build macro RR_LOCK_EN adds in_last[N] for multi-word locked bursts.
module rr_mux_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = DEF_N,
    parameter  int W  = DEF_W,
    localparam int SW = sw_of(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
`ifdef RR_LOCK_EN
    input  logic [N-1:0]    in_last,
`endif
    output logic [N-1:0]    in_ready,
    output logic [SW-1:0]   sel,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_src,
    input  logic            out_ready
);

    logic          load_en;
    logic          any;
    logic          xfer;
    logic [N-1:0]  req_m;
    logic [N-1:0]  gnt;
    logic [SW-1:0] ptr_q;
    logic [SW-1:0] ptr_m;
    logic [SW-1:0] ptr_nx;
    logic [SW-1:0] idx;

    // No grant is offered while reset is held.
    assign load_en = rst_n & (out_ready | ~out_valid);

`ifdef RR_LOCK_EN
    logic          lock_q;
    logic [SW-1:0] lock_idx_q;
    logic          last_bit;

    // While locked only the owner may request.
    assign req_m = lock_q ? (in_valid & (N'(1) << lock_idx_q))
                          : in_valid;
    assign ptr_m = lock_q ? lock_idx_q : ptr_q;
    assign last_bit = in_last[idx];
`else
    assign req_m = in_valid;
    assign ptr_m = ptr_q;
`endif

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req (req_m),
        .ptr (ptr_m),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    assign xfer     = load_en & any;
    assign in_ready = {N{load_en}} & gnt;
    assign sel      = idx;
    assign ptr_nx   = (idx == SW'(N - 1)) ? '0 : idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load_en) begin
            out_valid <= any;
            if (any) begin
                out_data <= in_data[idx*W +: W];
                out_src  <= idx;
            end
        end
    end

`ifdef RR_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= SW'(RST_PTR);
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (xfer) begin
            if (last_bit) begin
                ptr_q  <= ptr_nx;
                lock_q <= 1'b0;
            end else begin
                lock_q     <= 1'b1;
                lock_idx_q <= idx;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SW'(RST_PTR);
        end else if (xfer) begin
            ptr_q <= ptr_nx;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized and directed bench for rr_mux_arbiter against a queue-free
// behavioural round-robin model.
module tb_rr_mux_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [SW-1:0]   sel;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_src;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    // Model state.
    int       m_ptr;
    bit       m_valid;
    int       m_data;
    int       m_src;
    bit       m_lock;
    int       m_lidx;
    // Model combinational results for the current inputs.
    int       g;
    bit       load;
    int       exp_sel;
    int       exp_ready;

    always #5 clk = ~clk;

    rr_mux_arbiter #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_data  = 0;
        m_src   = 0;
        m_lock  = 0;
        m_lidx  = 0;
    endtask

    // Who would win right now, from the arbitration rules.
    task automatic model_comb();
        load = rst_n && (out_ready || !m_valid);
        g = -1;
        if (m_lock) begin
            if (in_valid[m_lidx]) g = m_lidx;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && in_valid[(m_ptr + k) % N])
                    g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) exp_sel = g;
        else exp_sel = m_lock ? m_lidx : m_ptr;
        exp_ready = (load && g >= 0) ? (1 << g) : 0;
    endtask

    task automatic model_seq();
        if (!load) return;
        if (g < 0) begin
            m_valid = 0;
            return;
        end
        m_valid = 1;
        m_data  = int'(in_data[g*W +: W]);
        m_src   = g;
`ifdef RR_LOCK_EN
        if (!in_last[g]) begin
            m_lock = 1;
            m_lidx = g;
        end else begin
            m_lock = 0;
            m_ptr  = (g + 1) % N;
        end
`else
        m_ptr = (g + 1) % N;
`endif
    endtask

    // Inputs are set; settle, evaluate model, clock, land mid-low phase.
    task automatic tick();
        @(posedge clk);
        model_seq();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        in_valid  = '1;
        in_last   = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00
            || out_src !== 2'd0 || in_ready !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: v=%b d=%h s=%0d rdy=%b req 0/00/0/0000",
                     out_valid, out_data, out_src, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        model_comb();
        checks++;
        if (in_ready !== 4'b0001 || sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant: rdy=%b sel=%0d req 0001/0",
                     in_ready, sel);
        end
        tick();
        checks++;
        if (out_src !== 2'd0 || out_data !== 8'h10) begin
            errors++;
            $display("FAIL reset_first_word: src=%0d d=%h req 0/10",
                     out_src, out_data);
        end
    endtask

    task automatic test_contention();
        do_reset();
        in_valid  = '1;
        in_last   = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
        for (int k = 0; k < 5; k++) begin
            #1;
            model_comb();
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(k % N)
                || out_src !== SW'(k % N)) begin
                errors++;
                $display("FAIL contention[%0d]: v=%b d=%h s=%0d req 1/%h/%0d",
                         k, out_valid, out_data, out_src,
                         8'h10 + 8'(k % N), k % N);
            end
        end
    endtask

    // Continues from contention: word 10 held, pointer at 1.
    task automatic test_backpressure();
        logic [W-1:0]  hd;
        logic [SW-1:0] hs;
        hd = out_data;
        hs = out_src;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            model_comb();
            checks++;
            if (in_ready !== 4'h0 || sel !== 2'd1) begin
                errors++;
                $display("FAIL stall_ready[%0d]: rdy=%b sel=%0d req 0000/1",
                         k, in_ready, sel);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== hd || out_src !== hs) begin
                errors++;
                $display("FAIL stall_hold[%0d]: v=%b d=%h s=%0d req 1/%h/%0d",
                         k, out_valid, out_data, out_src, hd, hs);
            end
        end
        out_ready = 1'b1;
        #1;
        model_comb();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 2'd1) begin
            errors++;
            $display("FAIL stall_release: v=%b d=%h s=%0d req 1/11/1",
                     out_valid, out_data, out_src);
        end
    endtask

    task automatic test_sparse_wrap();
        do_reset();
        out_ready = 1'b1;
        in_last   = '1;
        in_valid  = 4'b1000;
        #1;
        model_comb();
        tick();
        checks++;
        if (out_src !== 2'd3 || out_data !== 8'h13) begin
            errors++;
            $display("FAIL sparse_3: s=%0d d=%h req 3/13", out_src, out_data);
        end
        in_valid = 4'b0000;
        #1;
        checks++;
        if (sel !== 2'd0) begin
            errors++;
            $display("FAIL wrap_ptr0: sel=%0d req 0", sel);
        end
        in_valid = 4'b0010;
        #1;
        model_comb();
        tick();
        checks++;
        if (out_src !== 2'd1 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL sparse_1: s=%0d d=%h req 1/11", out_src, out_data);
        end
        in_valid = 4'b0000;
        #1;
        checks++;
        if (sel !== 2'd2) begin
            errors++;
            $display("FAIL wrap_ptr2: sel=%0d req 2", sel);
        end
    endtask

    task automatic test_idle_drain();
        do_reset();
        out_ready = 1'b1;
        in_last   = '1;
        in_valid  = 4'b0100;
        #1;
        model_comb();
        tick();
        in_valid = 4'b0000;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h12) begin
            errors++;
            $display("FAIL drain_load: v=%b d=%h req 1/12", out_valid, out_data);
        end
        #1;
        model_comb();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h12 || out_src !== 2'd2) begin
            errors++;
            $display("FAIL drain_empty: v=%b d=%h s=%0d req 0/12/2",
                     out_valid, out_data, out_src);
        end
    endtask

    task automatic test_reset_mid_stall();
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        #1;
        model_comb();
        tick();
        in_valid = 4'b0000;
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_stall: v=%b d=%h s=%0d req 0/00/0",
                     out_valid, out_data, out_src);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
    endtask

`ifdef RR_LOCK_EN
    task automatic test_lock();
        logic [N-1:0] lseq [3];
        lseq[0] = 4'b1011;
        lseq[1] = 4'b1011;
        lseq[2] = 4'b1111;
        do_reset();
        out_ready = 1'b1;
        in_last   = '1;
        in_valid  = 4'b0010;
        #1;
        model_comb();
        tick();
        in_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            in_last = lseq[k];
            #1;
            model_comb();
            checks++;
            if (in_ready !== 4'b0100) begin
                errors++;
                $display("FAIL lock_ready[%0d]: rdy=%b req 0100", k, in_ready);
            end
            tick();
            checks++;
            if (out_src !== 2'd2) begin
                errors++;
                $display("FAIL lock_src[%0d]: s=%0d req 2", k, out_src);
            end
        end
        in_last = '1;
        #1;
        model_comb();
        tick();
        checks++;
        if (out_src !== 2'd0) begin
            errors++;
            $display("FAIL lock_release: s=%0d req 0", out_src);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = N'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) in_valid = '0;
            in_data   = $urandom;
            in_last   = N'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_comb();
            checks++;
            if (in_ready !== N'(exp_ready) || sel !== SW'(exp_sel)) begin
                errors++;
                $display("FAIL rand_comb[%0d]: rdy=%b sel=%0d req %b/%0d",
                         c, in_ready, sel, N'(exp_ready), exp_sel);
            end
            tick();
            checks++;
            if (out_valid !== m_valid || out_data !== W'(m_data)
                || out_src !== SW'(m_src)) begin
                errors++;
                $display("FAIL rand_out[%0d]: v=%b d=%h s=%0d req %b/%h/%0d",
                         c, out_valid, out_data, out_src,
                         m_valid, W'(m_data), m_src);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '1;
        out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_contention();
        test_backpressure();
        test_sparse_wrap();
        test_idle_drain();
        test_reset_mid_stall();
`ifdef RR_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
